// File: rtl/softmax_pkg.sv
// Shared types and fixed-point constants for the softmax unit.
package softmax_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAX,
        S_EXP,
        S_DIV,
        S_DONE
    } state_e;

    // Constants are given scaled by 1e7 and rounded to the target fraction width.
    function automatic int fx_round(input longint val_e7, input int fp);
        return int'((val_e7 * (64'sd1 << fp) + 64'sd5000000) / 64'sd10000000);
    endfunction

    function automatic int log2e_q(input int fp);
        return fx_round(64'sd14426950, fp);
    endfunction

    function automatic int exp2_c1(input int fp);
        return fx_round(64'sd6565000, fp);
    endfunction

    function automatic int exp2_c2(input int fp);
        return fx_round(64'sd3435000, fp);
    endfunction

    function automatic int exp_w(input int fp);
        return fp + 1;
    endfunction

    function automatic int sum_w(input int fp, input int n);
        return fp + 1 + $clog2(n);
    endfunction

endpackage

// File: rtl/softmax_exp.sv
// Combinational exp(d) for d <= 0: exp(d) = 2^(d*log2e), split into integer shift and a
// quadratic approximation of the fractional power.
module softmax_exp
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8
) (
    input  logic signed [DATA_WIDTH:0]  d_i,
    output logic        [FIXED_PNT:0]   e_o
);
    localparam int LOG2E = log2e_q(FIXED_PNT);
    localparam int C1    = exp2_c1(FIXED_PNT);
    localparam int C2    = exp2_c2(FIXED_PNT);
    localparam int PW    = DATA_WIDTH + FIXED_PNT + 4;
    localparam int MW    = 2 * FIXED_PNT + 4;

    logic signed [PW-1:0] d_ext, k_log2e, prod, t, n;
    logic        [MW-1:0] f, inner, poly;

    always_comb begin
        d_ext   = $signed({{(PW-DATA_WIDTH-1){d_i[DATA_WIDTH]}}, d_i});
        k_log2e = PW'(LOG2E);
        prod    = d_ext * k_log2e;
        t       = prod >>> FIXED_PNT;
        // floor(t) is -n; the low bits are the fraction f in [0,1)
        n       = -(t >>> FIXED_PNT);
        f       = MW'(t[FIXED_PNT-1:0]);
        inner   = MW'(C1) + ((MW'(C2) * f) >> FIXED_PNT);
        poly    = (MW'(1) << FIXED_PNT) + ((f * inner) >> FIXED_PNT);
        if (n > PW'(FIXED_PNT))
            e_o = '0;
        else
            e_o = (FIXED_PNT+1)'(poly >> n);
    end

endmodule

// File: rtl/softmax_unit.sv
// Sequential fixed-point softmax: max search, exp with running sum, then restoring division
// of each exp term by the sum.
module softmax_unit
    import softmax_pkg::*;
#(
    parameter int VEC_SIZE   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_in,
    input  logic                                  enable,
    input  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]   vec_in,
    output logic                                  data_ready,
    output logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]   vec_out
);
    localparam int EXP_W = exp_w(FIXED_PNT);
    localparam int SUM_W = sum_w(FIXED_PNT, VEC_SIZE);
    localparam int IDX_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
    localparam int BIT_W = $clog2(FIXED_PNT + 1);

    state_e                                state_q;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]   x_q;
    logic signed [DATA_WIDTH-1:0]          m_q;
    logic [VEC_SIZE-1:0][EXP_W-1:0]        e_q;
    logic [SUM_W-1:0]                      sum_q;
    logic [SUM_W:0]                        rem_q;
    logic [EXP_W-1:0]                      quo_q;
    logic [IDX_W-1:0]                      idx_q;
    logic [BIT_W-1:0]                      bit_q;
    logic                                  ready_q;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]   out_q;

    logic [DATA_WIDTH-1:0]                 x_sel;
    logic signed [DATA_WIDTH:0]            diff_d;
    logic [EXP_W-1:0]                      e_d;
    logic                                  ge_d, last_d;
    logic [SUM_W:0]                        rem_sub_d, rem_shift_d;
    logic [EXP_W-1:0]                      quo_d;

    always_comb begin
        x_sel       = x_q[idx_q];
        diff_d      = $signed({x_sel[DATA_WIDTH-1], x_sel}) - $signed({m_q[DATA_WIDTH-1], m_q});
        last_d      = (idx_q == IDX_W'(VEC_SIZE - 1));
        ge_d        = (rem_q >= (SUM_W+1)'(sum_q));
        rem_sub_d   = ge_d ? rem_q - (SUM_W+1)'(sum_q) : rem_q;
        rem_shift_d = rem_sub_d << 1;
        quo_d       = (quo_q << 1) | EXP_W'(ge_d);
    end

    softmax_exp #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIXED_PNT  (FIXED_PNT)
    ) u_exp (
        .d_i (diff_d),
        .e_o (e_d)
    );

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            m_q     <= '0;
            e_q     <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            ready_q <= 1'b0;
            out_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (enable) begin
                    x_q     <= vec_in;
                    m_q     <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
                    sum_q   <= '0;
                    idx_q   <= '0;
                    state_q <= S_MAX;
                end
                S_MAX: begin
                    if ($signed(x_sel) > m_q)
                        m_q <= $signed(x_sel);
                    if (last_d) begin
                        idx_q   <= '0;
                        state_q <= S_EXP;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_EXP: begin
                    e_q[idx_q] <= e_d;
                    sum_q      <= sum_q + SUM_W'(e_d);
                    if (last_d) begin
                        idx_q   <= '0;
                        bit_q   <= '0;
                        rem_q   <= (SUM_W+1)'((VEC_SIZE == 1) ? e_d : e_q[0]);
                        state_q <= S_DIV;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_shift_d;
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == BIT_W'(FIXED_PNT)) begin
                        out_q[idx_q] <= DATA_WIDTH'(quo_d);
                        bit_q        <= '0;
                        if (last_d) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            rem_q <= (SUM_W+1)'(e_q[idx_q + 1'b1]);
                        end
                    end
                end
                S_DONE: begin
                    // First DONE cycle raises the flag; it then drops on the first low enable.
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (!enable) begin
                        ready_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_ready = ready_q;
    assign vec_out    = out_q;

endmodule

// File: tb/tb_softmax_unit.sv
// Directed bench for softmax_unit with a queue scoreboard checked by an independent monitor.
module tb_softmax_unit;
    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int LAT = 34;

    logic               clk = 1'b0;
    logic               rst_in = 1'b1;
    logic               enable = 1'b0;
    logic [N-1:0][DW-1:0] vec_in = '0;
    logic               data_ready;
    logic [N-1:0][DW-1:0] vec_out;

    typedef struct {
        int e0;
        int e1;
        int e2;
        int tol;
        int cap;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_rdy = 1'b0;

    softmax_unit dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .enable     (enable),
        .vec_in     (vec_in),
        .data_ready (data_ready),
        .vec_out    (vec_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req, input int tol);
        checks++;
        if (act < req - tol || act > req + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, req, tol);
        end
    endtask

    // Monitor: every rising data_ready must match the oldest queued expectation.
    always @(negedge clk) begin
        if (data_ready && !prev_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 1, 0, 0);
            end else begin
                exp_t e;
                int s;
                e = sb.pop_front();
                chk("latency", cyc - e.cap, LAT, 0);
                chk("out0", int'($signed(vec_out[0])), e.e0, e.tol);
                chk("out1", int'($signed(vec_out[1])), e.e1, e.tol);
                chk("out2", int'($signed(vec_out[2])), e.e2, e.tol);
                s = int'($signed(vec_out[0])) + int'($signed(vec_out[1])) + int'($signed(vec_out[2]));
                chk("out_sum", s, 256, N);
            end
        end
        prev_rdy <= data_ready;
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 0, 1, 0);
    endtask

    // drop_after > 0: release enable that many cycles after start; hold: extra cycles with enable high after ready.
    task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input int e0, input int e1, input int e2, input int tol,
                       input int drop_after, input int hold);
        bit ok;
        logic [N-1:0][DW-1:0] snap;
        exp_t e;
        @(negedge clk);
        vec_in = {c, b, a};
        enable = 1'b1;
        e = '{e0, e1, e2, tol, cyc + 1};
        sb.push_back(e);
        @(negedge clk);
        vec_in = {16'h7123, 16'h8456, 16'h0789};
        if (drop_after > 0) begin
            repeat (drop_after - 1) @(negedge clk);
            enable = 1'b0;
        end
        wait_ready(ok);
        if (!ok) return;
        if (drop_after > 0) begin
            @(negedge clk);
            chk("single_pulse", int'(data_ready), 0, 0);
            return;
        end
        snap = vec_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ready", int'(data_ready), 1, 0);
            chk("hold_stable", int'(vec_out == snap), 1, 0);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("ready_drop", int'(data_ready), 0, 0);
    endtask

    initial begin
        bit seen;
        repeat (4) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(data_ready), 0, 0);
        chk("rst_vec_out", int'(vec_out == '0), 1, 0);
        repeat (5) @(negedge clk);
        chk("idle_ready", int'(data_ready), 0, 0);
        chk("idle_vec_out", int'(vec_out == '0), 1, 0);

        run(16'h0400, 16'h0600, 16'h0500, 23, 170, 63, 2, 0, 0);
        run(16'h0100, 16'h0100, 16'h0100, 85, 85, 85, 1, 0, 0);
        run(16'h7FFF, 16'h8000, 16'h8000, 256, 0, 0, 0, 0, 0);
        run(16'h0400, 16'h0600, 16'h0500, 23, 170, 63, 2, 0, 10);
        run(16'h0000, 16'h0000, 16'hFF00, 108, 108, 40, 2, 0, 0);

        // Abort mid-division: no result must follow.
        @(negedge clk);
        vec_in = {16'h0500, 16'h0600, 16'h0400};
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (18) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        chk("abort_ready", int'(data_ready), 0, 0);
        chk("abort_vec_out", int'(vec_out == '0), 1, 0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (data_ready) seen = 1'b1;
        end
        chk("abort_no_ready", int'(seen), 0, 0);

        run(16'h0400, 16'h0600, 16'h0500, 23, 170, 63, 2, 5, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
